// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arb_pick4.sv
// Rotating first-set-bit finder: scans mask from start upward, wrapping modulo 4.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] mask,
    input  logic [ID_W-1:0]    start,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    always_comb begin
        logic [ID_W-1:0] pos;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = start + ID_W'(k);
            if (!found && mask[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Optional hold-limit revocation is built when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter_4
    import rr_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic               any_req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_cfg
        $error("rr_arbiter_4: HOLD_MAX must be 2..255 and fit in CNT_W bits");
    end

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [ID_W-1:0]    id_d;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [ID_W-1:0]    next_id;
    logic [ID_W-1:0]    start;
    logic [ID_W-1:0]    idx;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] gnt_d;
    logic               found;
    logic               valid_d;
    logic               owner_req;

`ifdef RR_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               to_d;

    assign cnt_inc = (cnt_q == CNT_W'(HOLD_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
`else
    assign timeout = 1'b0;
`endif

    assign any_req   = |req;
    assign owner_req = req[gnt_id];
    assign next_id   = gnt_id + ID_W'(1);

    // While owned, the current owner is excluded and the scan starts just past it.
    assign start = (state_q == ARB_OWNED) ? next_id : ptr_q;
    assign mask  = (state_q == ARB_OWNED) ? (req & ~onehot4(gnt_id)) : req;

    rr_pick4 u_pick (
        .mask  (mask),
        .start (start),
        .idx   (idx),
        .found (found)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt       <= gnt_d;
            gnt_id    <= id_d;
            gnt_valid <= valid_d;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout   <= to_d;
`endif
        end
    end

    // Next ownership, pointer and hold count.
    always_comb begin
        state_d = state_q;
        id_d    = gnt_id;
        ptr_d   = ptr_q;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    state_d = ARB_OWNED;
                    id_d    = idx;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ARB_OWNED: begin
                if (!owner_req) begin
                    ptr_d = next_id;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    if (found) begin
                        id_d = idx;
                    end else begin
                        state_d = ARB_IDLE;
                        id_d    = '0;
                    end
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (found && cnt_inc == CNT_W'(HOLD_MAX)) begin
                    id_d  = idx;
                    ptr_d = next_id;
                    cnt_d = '0;
                    to_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            default: begin
                state_d = ARB_IDLE;
                id_d    = '0;
            end
        endcase
    end

    // Grant vector and valid follow the next owner.
    always_comb begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (state_d == ARB_OWNED) begin
            gnt_d   = onehot4(id_d);
            valid_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus randomized traffic
// against a behavioural round-robin model. Covers RR_ARB_TIMEOUT_EN when defined.
module tb_rr_arbiter_4;

    localparam int unsigned HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       any_req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: owner index (-1 = none), pointer, hold edges, timeout pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    rr_arbiter_4 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .any_req   (any_req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic int sel(input logic [3:0] m, input int s);
        for (int k = 0; k < 4; k++) begin
            if (m[(s + k) % 4]) return (s + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        logic [3:0] others;
        int o;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                m_owner = sel(req, m_ptr);
                m_held  = 0;
            end else if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = sel(req, m_ptr);
                m_held  = 0;
            end else begin
                m_held++;
`ifdef RR_ARB_TIMEOUT_EN
                o      = m_owner;
                others = req;
                others[o] = 1'b0;
                if (others != 4'b0000 && m_held >= int'(HOLD)) begin
                    m_ptr   = (o + 1) % 4;
                    m_owner = sel(others, m_ptr);
                    m_held  = 0;
                    m_to    = 1'b1;
                end
`else
                o      = 0;
                others = 4'b0000;
`endif
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] eg;
        if (chk_en) begin
            eg = 4'b0000;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            check("model_gnt", 32'(gnt), 32'(eg));
            check("model_gnt_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
            check("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
            check("model_timeout", 32'(timeout), 32'(m_to));
            check("model_any_req", 32'(any_req), 32'(req != 4'b0000));
        end
    end

    initial begin
        int exp_o;
        logic [3:0] onehot;

        // Reset held with all requests pending.
        rst = 1'b1;
        req = 4'b1111;
        tick();
        chk_en = 1'b1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        tick();
        check("rst_gnt2", 32'(gnt), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'b0001);
        check("post_rst_id", 32'(gnt_id), 32'd0);

        // Basic grant / hold / release, then pointer wrap from 3 to 0.
        req = 4'b0000;
        tick();
        check("release_idle", 32'(gnt), 32'h0);
        req = 4'b0100;
        tick();
        check("grant2", 32'(gnt), 32'b0100);
        check("grant2_id", 32'(gnt_id), 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold2", 32'(gnt), 32'b0100);
        end
        req = 4'b0000;
        tick();
        check("drop2", 32'(gnt), 32'h0);
        check("drop2_valid", 32'(gnt_valid), 32'h0);
        req = 4'b0101;
        tick();
        check("wrap_to0", 32'(gnt), 32'b0001);
        req = 4'b0000;
        tick();

        // Back-to-back rotation from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        tick();
        exp_o = 0;
        for (int r = 0; r < 5; r++) begin
            onehot = 4'b0001 << exp_o;
            for (int c = 0; c < 3; c++) begin
                check("rot_gnt", 32'(gnt), 32'(onehot));
                if (c < 2) tick();
            end
            req = 4'b1111 & ~onehot;
            tick();
            exp_o = (exp_o + 1) % 4;
            req = 4'b1111;
            check("rot_valid", 32'(gnt_valid), 32'h1);
        end

        // any_req sweep with reset held.
        rst = 1'b1;
        tick();
        for (int v = 0; v < 16; v++) begin
            req = 4'(v);
            #1;
            check("any_req_sweep", 32'(any_req), 32'(v != 0));
            tick();
            check("sweep_gnt", 32'(gnt), 32'h0);
        end

        // Reset in the middle of a grant restarts from pointer 0.
        rst = 1'b0;
        req = 4'b0100;
        tick();
        check("mid_grant", 32'(gnt), 32'b0100);
        rst = 1'b1;
        tick();
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        rst = 1'b0;
        req = 4'b1100;
        tick();
        check("after_mid_rst", 32'(gnt), 32'b0100);

        // Hold limit behaviour.
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        req = 4'b0011;
        tick();
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            check("to_hold0", 32'(gnt), 32'b0001);
            tick();
        end
        check("to_hold0_last", 32'(gnt), 32'b0001);
        tick();
        check("to_revoke", 32'(gnt), 32'b0010);
        check("to_pulse", 32'(timeout), 32'h1);
        tick();
        check("to_pulse_end", 32'(timeout), 32'h0);
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("lone_keep", 32'(gnt), 32'b0001);
            check("lone_no_to", 32'(timeout), 32'h0);
        end
`else
        for (int i = 0; i < 20; i++) begin
            check("no_revoke", 32'(gnt), 32'b0001);
            check("no_timeout", 32'(timeout), 32'h0);
            tick();
        end
`endif

        // Randomized traffic with sticky requests and occasional reset.
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) req[b] = ~req[b];
            end
            rst = ($urandom_range(63) == 0);
            tick();
        end
        rst = 1'b0;
        req = 4'b0000;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
